// File: rtl/rf_init_pkg.sv
// Shared types, defaults and power-up register table for the RF init sequencer.
// RF_INIT_LOOP_EN adds the GAP state used when the table is replayed forever.
package rf_init_pkg;

    localparam int WORD_W             = 40;
    localparam int DEF_NUM_WORDS      = 16;
    localparam int DEF_RESET_CYCLES   = 2000;
    localparam int DEF_WAIT_CYCLES    = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_RST_WAIT,
        ST_FETCH,
        ST_PRESENT,
`ifdef RF_INIT_LOOP_EN
        ST_DONE,
        ST_GAP
`else
        ST_DONE
`endif
    } state_t;

    // Each word is {8-bit register address, 32-bit payload}.
    localparam logic [WORD_W-1:0] INIT_TABLE [DEF_NUM_WORDS] = '{
        40'h00_0000_0001, 40'h01_0000_00A5, 40'h02_1234_5678, 40'h03_DEAD_BEEF,
        40'h04_0000_FFFF, 40'h05_FFFF_0000, 40'h06_8000_0001, 40'h07_0F0F_0F0F,
        40'h10_C001_D00D, 40'h11_0000_0010, 40'h12_5555_AAAA, 40'h13_AAAA_5555,
        40'h20_0102_0304, 40'h21_F00D_CAFE, 40'h30_7FFF_FFFF, 40'h3F_0000_0000
    };

    // Entries beyond the fixed table are filled with an address-tagged pattern.
    function automatic logic [WORD_W-1:0] table_word(input logic [7:0] idx);
        if (idx < 8'(DEF_NUM_WORDS)) begin
            return INIT_TABLE[idx[3:0]];
        end
        return {idx, 8'h5A, 16'h0000, ~idx};
    endfunction

endpackage

// File: rtl/rf_init_rom.sv
// Init word table with a registered one-cycle read; output holds between reads.
// Read data resets to zero so no stale word survives a system reset.
module rf_init_rom
    import rf_init_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [7:0]        addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] data_d;
    logic [WORD_W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (rd_en && (int'(addr) < NUM_WORDS)) begin
            data_d = table_word(addr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/rf_init_sequencer.sv
// RF chip bring-up: hold XRESET low, settle, then stream the init table to the SPI serializer.
// Define RF_INIT_LOOP_EN to replay the table forever with a WAIT_CYCLES gap between passes.
module rf_init_sequencer
    import rf_init_pkg::*;
#(
    parameter int NUM_WORDS    = DEF_NUM_WORDS,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        rf_xreset,
    output logic [39:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  word_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] RST_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_WORDS - 1);

    state_t      state_d, state_q;
    logic [15:0] cnt_d, cnt_q;
    logic [7:0]  idx_d, idx_q;
    logic        xreset_d, xreset_q;
    logic        valid_d, valid_q;
    logic        busy_d, busy_q;
    logic        done_d, done_q;
    logic        rd_en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        xreset_d = xreset_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rd_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RST_ASSERT;
                    cnt_d    = RST_LOAD;
                    idx_d    = '0;
                    xreset_d = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            ST_RST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RST_WAIT;
                    cnt_d    = WAIT_LOAD;
                    xreset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_FETCH: begin
                // ROM output lands on the same edge that raises word_valid.
                rd_en   = 1'b1;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
`ifdef RF_INIT_LOOP_EN
                        state_d = ST_GAP;
                        cnt_d   = WAIT_LOAD;
                        idx_d   = '0;
                        done_d  = 1'b1;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef RF_INIT_LOOP_EN
            ST_GAP: begin
                done_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            xreset_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            xreset_q <= xreset_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    rf_init_rom #(
        .NUM_WORDS(NUM_WORDS)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .rd_en  (rd_en),
        .addr   (idx_q),
        .rd_data(word_data)
    );

    assign rf_xreset  = xreset_q;
    assign word_valid = valid_q;
    assign word_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rf_init_sequencer.sv
// Bench for rf_init_sequencer: random ready/start stimulus against a table-and-timing reference.
module tb_rf_init_sequencer;

    localparam int NW = 16;
    localparam int RC = 2000;
    localparam int WC = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rf_xreset;
    logic [39:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  word_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [39:0] exp_tbl [NW];

    always #5 clk = ~clk;

    rf_init_sequencer #(
        .NUM_WORDS   (NW),
        .RESET_CYCLES(RC),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rf_xreset (rf_xreset),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_idx  (word_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_xreset"}, 64'(rf_xreset), 64'd0);
        check_eq({tag, "_valid"},  64'(word_valid), 64'd0);
        check_eq({tag, "_data"},   64'(word_data), 64'd0);
        check_eq({tag, "_idx"},    64'(word_idx), 64'd0);
        check_eq({tag, "_busy"},   64'(busy), 64'd0);
        check_eq({tag, "_done"},   64'(done), 64'd0);
    endtask

    // One sequence from start. j is the number of edges since start was sampled.
    task automatic run_pass(input bit rand_rdy, input bit pokes, input int stall_word,
                            input int abort_word);
        int  j;
        int  exp_idx;
        int  xfer_j;
        int  hold_j;
        int  stall_left;
        bit  r;
        bit  fin;
        @(negedge clk);
        start      = 1'b1;
        word_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        j          = -1;
        exp_idx    = 0;
        xfer_j     = -10;
        hold_j     = -10;
        stall_left = 50;
        fin        = 1'b0;
        while (!fin) begin
            @(negedge clk);
            j++;
            start = 1'b0;
            check_eq("xreset_level", 64'(rf_xreset), 64'(j >= RC));
            check_eq("busy_run", 64'(busy), 64'd1);
            check_eq("done_run", 64'(done), 64'd0);
            if (j <= RC + WC + 1)
                check_eq("first_valid_time", 64'(word_valid), 64'(j == RC + WC + 1));
            if (j == xfer_j + 1) begin
                check_eq("bubble_valid", 64'(word_valid), 64'd0);
                check_eq("bubble_data_held", 64'(word_data), 64'(exp_tbl[exp_idx-1]));
            end else if (j == xfer_j + 2) begin
                check_eq("next_valid_2cyc", 64'(word_valid), 64'd1);
            end
            if (j == hold_j + 1)
                check_eq("valid_held_stall", 64'(word_valid), 64'd1);
            if (word_valid) begin
                check_eq("word_data", 64'(word_data), 64'(exp_tbl[exp_idx]));
                check_eq("word_idx", 64'(word_idx), 64'(exp_idx));
            end
            if (abort_word >= 0 && word_valid && exp_idx == abort_word) begin
                reset = 1'b1;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                reset      = 1'b0;
                word_ready = 1'b0;
                return;
            end
            if (stall_word == exp_idx && word_valid && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else begin
                r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            word_ready = r;
            if (pokes)
                start = ($urandom_range(0, 3) == 0);
            if (word_valid && !r)
                hold_j = j;
            if (word_valid && r) begin
                if (exp_idx == NW - 1) begin
                    @(negedge clk);
                    start      = 1'b0;
                    word_ready = 1'b0;
                    check_eq("end_done", 64'(done), 64'd1);
                    check_eq("end_busy", 64'(busy), 64'd0);
                    check_eq("end_valid", 64'(word_valid), 64'd0);
                    check_eq("end_idx", 64'(word_idx), 64'(NW - 1));
                    check_eq("end_xreset", 64'(rf_xreset), 64'd1);
                    fin = 1'b1;
                end else begin
                    xfer_j = j;
                    exp_idx++;
                end
            end
            if (!fin && j > RC + WC + 3000) begin
                check_eq("pass_timeout", 64'(j), 64'(RC + WC + 3000));
                fin = 1'b1;
            end
        end
        start      = 1'b0;
        word_ready = 1'b0;
    endtask

    initial begin
        exp_tbl = '{
            40'h00_0000_0001, 40'h01_0000_00A5, 40'h02_1234_5678, 40'h03_DEAD_BEEF,
            40'h04_0000_FFFF, 40'h05_FFFF_0000, 40'h06_8000_0001, 40'h07_0F0F_0F0F,
            40'h10_C001_D00D, 40'h11_0000_0010, 40'h12_5555_AAAA, 40'h13_AAAA_5555,
            40'h20_0102_0304, 40'h21_F00D_CAFE, 40'h30_7FFF_FFFF, 40'h3F_0000_0000
        };
        reset      = 1'b1;
        start      = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        word_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("idle");

        // Full pass with ready tied high.
        run_pass(1'b0, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        check_eq("done_hold", 64'(done), 64'd1);
        check_eq("done_xreset_hold", 64'(rf_xreset), 64'd1);
        check_eq("done_busy_hold", 64'(busy), 64'd0);

        // Restart from DONE: random ready, spurious starts, 50-cycle stall on word 3.
        run_pass(1'b1, 1'b1, 3, -1);

        // Restart from DONE, then async reset while word 7 is presented.
        run_pass(1'b1, 1'b0, -1, 7);
        repeat (3) @(negedge clk);
        check_reset_vals("post_abort");

        // Fresh sequence after reset replays from word 0.
        run_pass(1'b1, 1'b1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
